itr_ctrl: RTL and testbench



---
 rtl/itr_pkg.sv | 22 ++
 rtl/itr_ctrl_sync_edge.sv | 27 ++
 rtl/itr_ctrl.sv | 122 ++++++++++++
 tb/tb_itr_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/itr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding,
// default I/O address map and a small width helper.
package itr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Default I/O address map as seen from the core
  localparam int A_ID_DEF   = 0;  // in : active id + busy flag
  localparam int A_PEND_DEF = 1;  // in : pending vector
  localparam int A_MASK_DEF = 0;  // out: mask register
  localparam int A_EOI_DEF  = 1;  // out: end-of-interrupt strobe

  // Width needed to hold a source index; never below one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/itr_ctrl_sync_edge.sv
// One event line: 2-flop synchronizer followed by a registered
// rising-edge detector. rise is high for one cycle per low->high.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  // Synchronizer chain plus delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt controller: latches source edges as pending, masks them,
// picks the lowest-index eligible source, pulses itr for one cycle and
// waits for an EOI write before taking the next interrupt.
module itr_ctrl
  import itr_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int NSRC   = 8,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int A_ID   = A_ID_DEF,
  parameter int A_PEND = A_PEND_DEF,
  parameter int A_MASK = A_MASK_DEF,
  parameter int A_EOI  = A_EOI_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC-1:0]           src,
  input  logic                      io_wr_en,
  input  logic [$clog2(NUIOOU)-1:0] io_wr_addr,
  input  logic [NUBITS-1:0]         io_wr_data,
  input  logic                      io_rd_req,
  input  logic [$clog2(NUIOIN)-1:0] io_rd_addr,
  output logic [NUBITS-1:0]         io_rd_data,
  output logic                      io_rd_hit,
  output logic                      itr
);

  localparam int IDW = id_width(NSRC);
  localparam int AWI = $clog2(NUIOIN);
  localparam int AWO = $clog2(NUIOOU);

  state_t          state, state_nx;
  logic [NSRC-1:0] rise, pending, mask, eligible, clr;
  logic [IDW-1:0]  act_id, win_id;
  logic            latch_id, eoi, mask_we, eoi_we;

  // Bits of the write bus above the mask width carry nothing for us
  logic unused_wr;
  assign unused_wr = ^io_wr_data[NUBITS-1:NSRC];

  // Per-source synchronizer and edge detector
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    sync_edge u_se (
      .clk  (clk),
      .rst  (rst),
      .d    (src[g]),
      .rise (rise[g])
    );
  end

  assign mask_we  = io_wr_en && (io_wr_addr == AWO'(A_MASK));
  assign eoi_we   = io_wr_en && (io_wr_addr == AWO'(A_EOI));
  assign eligible = pending & mask;

  // Fixed priority: scan downwards so the lowest set index wins
  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (eligible[i]) win_id = IDW'(i);
  end

  // Next-state logic; EOI only counts while servicing
  always_comb begin
    state_nx = state;
    latch_id = 1'b0;
    eoi      = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nx = FIRE;
          latch_id = 1'b1;
        end
      end
      FIRE: state_nx = SERVICE;
      SERVICE: begin
        if (eoi_we) begin
          state_nx = IDLE;
          eoi      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pending bit of the serviced source drops on EOI; a new edge wins
  assign clr = eoi ? (NSRC'(1) << act_id) : '0;

  // State, registered itr, active id, mask and pending registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      itr     <= 1'b0;
      act_id  <= '0;
      mask    <= '0;
      pending <= '0;
    end else begin
      state   <= state_nx;
      itr     <= (state_nx == FIRE);
      if (latch_id) act_id <= win_id;
      if (mask_we)  mask   <= io_wr_data[NSRC-1:0];
      pending <= (pending & ~clr) | rise;
    end
  end

  // Zero-latency read mux; drives zero when the read is not ours
  always_comb begin
    io_rd_data = '0;
    io_rd_hit  = 1'b0;
    if (io_rd_req) begin
      if (io_rd_addr == AWI'(A_ID)) begin
        io_rd_hit             = 1'b1;
        io_rd_data[IDW-1:0]   = act_id;
        io_rd_data[NUBITS-1]  = (state == SERVICE);
      end else if (io_rd_addr == AWI'(A_PEND)) begin
        io_rd_hit             = 1'b1;
        io_rd_data[NSRC-1:0]  = pending;
      end
    end
  end

endmodule

// File: tb/tb_itr_ctrl.sv
// Directed bench for itr_ctrl with hand-computed expectations.
module tb_itr_ctrl;

  localparam logic [2:0] A_ID = 3'd0, A_PEND = 3'd1, A_MASK = 3'd0, A_EOI = 3'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src = '0;
  logic        io_wr_en = 1'b0;
  logic [2:0]  io_wr_addr = '0;
  logic [31:0] io_wr_data = '0;
  logic        io_rd_req = 1'b0;
  logic [2:0]  io_rd_addr = '0;
  logic [31:0] io_rd_data;
  logic        io_rd_hit;
  logic        itr;

  int checks = 0;
  int failures = 0;
  logic itr_seen;

  itr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .io_wr_en   (io_wr_en),
    .io_wr_addr (io_wr_addr),
    .io_wr_data (io_wr_data),
    .io_rd_req  (io_rd_req),
    .io_rd_addr (io_rd_addr),
    .io_rd_data (io_rd_data),
    .io_rd_hit  (io_rd_hit),
    .itr        (itr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    itr_seen = itr_seen | itr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    io_wr_en = 1'b1; io_wr_addr = a; io_wr_data = d;
    tick();
    io_wr_en = 1'b0; io_wr_addr = '0; io_wr_data = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    io_rd_req = 1'b1; io_rd_addr = a;
    #1;
    chk(tag, io_rd_data, exp);
    io_rd_req = 1'b0; io_rd_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0; io_wr_en = 1'b0; io_rd_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    itr_seen = 1'b0;
  endtask

  initial begin
    itr_seen = 1'b0;
    // Reset state, observed before any clock edge
    #1;
    chk("rst_itr", {31'd0, itr}, 32'd0);
    chk("rst_hit_idle", {31'd0, io_rd_hit}, 32'd0);
    chk("rst_data_idle", io_rd_data, 32'd0);
    do_reset();
    chk_rd("rst_id", A_ID, 32'h0);
    chk_rd("rst_pend", A_PEND, 32'h0);
    io_rd_req = 1'b1; io_rd_addr = 3'd5; #1;
    chk("foreign_hit", {31'd0, io_rd_hit}, 32'd0);
    chk("foreign_data", io_rd_data, 32'd0);
    io_rd_addr = A_PEND; #1;
    chk("pend_hit", {31'd0, io_rd_hit}, 32'd1);
    io_rd_req = 1'b0;

    // Masked source still latches pending but never interrupts
    itr_seen = 1'b0;
    src[3] = 1'b1;
    tick();
    src[3] = 1'b0;
    run(6);
    chk_rd("masked_pend", A_PEND, 32'h08);
    chk("masked_no_itr", {31'd0, itr_seen}, 32'd0);

    // Single source: latency and pulse width
    do_reset();
    wr(A_MASK, 32'hFF);
    src[5] = 1'b1;
    tick();                                   // E0
    chk("s5_e0_itr", {31'd0, itr}, 32'd0);
    tick();                                   // E1
    tick();                                   // E2
    chk("s5_e2_itr", {31'd0, itr}, 32'd0);
    chk_rd("s5_e2_pend", A_PEND, 32'h20);
    tick();                                   // E3
    chk("s5_e3_itr", {31'd0, itr}, 32'd1);
    tick();                                   // E4
    chk("s5_e4_itr", {31'd0, itr}, 32'd0);
    chk_rd("s5_id_busy", A_ID, 32'h8000_0005);
    wr(A_EOI, 32'hDEAD);
    chk_rd("s5_id_done", A_ID, 32'h0000_0005);
    chk_rd("s5_pend_done", A_PEND, 32'h0);
    itr_seen = 1'b0;
    run(4);
    chk("s5_no_refire", {31'd0, itr_seen}, 32'd0);

    // Two simultaneous sources: lowest first, refire after one idle cycle
    do_reset();
    wr(A_MASK, 32'hFF);
    src = 8'h44;
    run(4);
    chk("pri_e3_itr", {31'd0, itr}, 32'd1);
    tick();
    chk_rd("pri_id_first", A_ID, 32'h8000_0002);
    wr(A_EOI, 32'h0);
    chk("pri_ex_itr", {31'd0, itr}, 32'd0);
    chk_rd("pri_ex_id", A_ID, 32'h0000_0002);
    chk_rd("pri_ex_pend", A_PEND, 32'h40);
    tick();
    chk("pri_refire_itr", {31'd0, itr}, 32'd1);
    tick();
    chk("pri_refire_drop", {31'd0, itr}, 32'd0);
    chk_rd("pri_id_second", A_ID, 32'h8000_0006);
    wr(A_EOI, 32'h0);
    chk_rd("pri_pend_done", A_PEND, 32'h0);

    // New edge on the active source lands on the EOI edge: set wins
    do_reset();
    wr(A_MASK, 32'hFF);
    src[1] = 1'b1;
    run(5);
    chk_rd("coll_busy", A_ID, 32'h8000_0001);
    src[1] = 1'b0;
    run(3);
    src[1] = 1'b1;
    tick();                                   // E0'
    tick();                                   // E1'
    io_wr_en = 1'b1; io_wr_addr = A_EOI; io_wr_data = '0;
    tick();                                   // E2': EOI and edge together
    io_wr_en = 1'b0;
    chk_rd("coll_pend", A_PEND, 32'h02);
    chk_rd("coll_idle", A_ID, 32'h0000_0001);
    tick();
    chk("coll_refire", {31'd0, itr}, 32'd1);
    tick();
    chk_rd("coll_busy2", A_ID, 32'h8000_0001);

    // EOI in IDLE ignored; mask cleared mid-service
    do_reset();
    wr(A_MASK, 32'hFF);
    wr(A_EOI, 32'h0);
    chk_rd("eoi_idle_id", A_ID, 32'h0);
    chk_rd("eoi_idle_pend", A_PEND, 32'h0);
    src[4] = 1'b1;
    run(4);
    chk("m0_itr", {31'd0, itr}, 32'd1);
    tick();
    wr(A_MASK, 32'h0);
    chk_rd("m0_still_busy", A_ID, 32'h8000_0004);
    src[0] = 1'b1;
    run(3);
    chk_rd("m0_pend_both", A_PEND, 32'h11);
    chk_rd("m0_busy_after", A_ID, 32'h8000_0004);
    wr(A_EOI, 32'h0);
    chk_rd("m0_id_done", A_ID, 32'h0000_0004);
    chk_rd("m0_pend_left", A_PEND, 32'h01);
    itr_seen = 1'b0;
    run(6);
    chk("m0_no_refire", {31'd0, itr_seen}, 32'd0);

    // Asynchronous reset during FIRE
    do_reset();
    wr(A_MASK, 32'hFF);
    src[7] = 1'b1;
    run(4);
    chk("arst_fire", {31'd0, itr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_itr_drop", {31'd0, itr}, 32'd0);
    src = '0;
    tick();
    rst = 1'b0;
    chk_rd("arst_id", A_ID, 32'h0);
    chk_rd("arst_pend", A_PEND, 32'h0);
    // Mask is back to zero: a fresh edge latches but does not fire
    itr_seen = 1'b0;
    src[0] = 1'b1;
    run(6);
    chk("arst_mask_zero", {31'd0, itr_seen}, 32'd0);
    chk_rd("arst_pend_new", A_PEND, 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
